// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//
// Receive side of a multiplexed, active-low seven-segment display bus.
// It samples the segment and anode lines and waits for each digit dwell
// to hold steady. It then decodes the segment pattern back to BCD and
// stores it in that digit's nibble. It serves as a loopback checker for
// the stopwatch display scanner.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   seg_n[7:0]  active-low segments: bit7 dp, bits6..0 = g,f,e,d,c,b,a
//   an_n        active-low digit selects, bit i = digit i
//   bcd_out     captured BCD, nibble i = digit i (F when blank/illegal)
//   dp_out      captured decimal point per digit, active-high
//   valid       nibble i holds a decoded 0-9 value
//   frame_done  one-cycle pulse after the last digit is captured
//   err         one-cycle pulse on an illegal pattern or anode combination

module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic                    frame_done,
    output logic                    err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_DIGITS + 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD,
        BAD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SW-1:0]           sample;
    logic [SW-1:0]           s_q;
    logic [CW-1:0]           cnt;
    logic                    changed;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [7:0]              seg_q;
    logic [6:0]              seg_on;
    logic                    an_idle;
    logic                    an_legal;
    logic [DW-1:0]           digit;
    logic [3:0]              dec_val;
    logic                    dec_valid;
    logic                    dec_blank;
    logic                    capture;
    logic                    bad_entry;

    assign sample   = {an_n, seg_n};
    assign changed  = (sample != s_q);
    assign an_q     = s_q[SW-1:8];
    assign seg_q    = s_q[7:0];
    assign seg_on   = ~seg_q[6:0];
    assign an_idle  = &an_q;
    assign an_legal = $onehot(~an_q);

    // Index of the single active anode; only meaningful when an_legal.
    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                digit = DW'(i);
            end
        end
    end

    // Segment pattern back to BCD. A blank digit is not an error; any
    // pattern outside the 0-9 set is.
    always_comb begin
        dec_val   = 4'hF;
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        case (seg_on)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            7'h00: begin
                dec_valid = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Dwell tracking. HELD leaves to SETTLE on any change, and SETTLE then
    // re-runs the anode check on the new sample. The restart therefore
    // lines up with the cnt clear, so every dwell gets the same latency.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (an_legal) begin
                    state_next = SETTLE;
                end else if (!an_idle) begin
                    state_next = BAD;
                end
            end
            SETTLE: begin
                if (an_idle) begin
                    state_next = IDLE;
                end else if (!an_legal) begin
                    state_next = BAD;
                end else if (!changed && (cnt == CNT_MAX)) begin
                    capture    = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (changed) begin
                    state_next = SETTLE;
                end
            end
            BAD: begin
                if (an_legal) begin
                    state_next = SETTLE;
                end else if (an_idle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bad_entry = (state_next == BAD) && (state != BAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q        <= '1;
            cnt        <= '0;
            state      <= IDLE;
            bcd_out    <= '1;
            dp_out     <= '0;
            valid      <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_q   <= sample;
            state <= state_next;
            if (changed) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            frame_done <= capture && (digit == DW'(NUM_DIGITS - 1));
            err        <= bad_entry || (capture && !dec_valid && !dec_blank);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (digit == DW'(i))) begin
                    bcd_out[4*i +: 4] <= dec_val;
                    valid[i]          <= dec_valid;
                    dp_out[i]         <= ~seg_q[7];
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
//
// Self-checking bench for seven_seg_capture (4 digits, 4 stable cycles).
// A reference model tracks how many consecutive edges the same
// {an_n, seg_n} value has been applied. A legal single-anode value that
// reaches STABLE_CYCLES+1 edges is captured once. An illegal anode value
// raises err on its second edge, unless the previous value was already
// illegal. Directed steps come first, followed by randomized dwells.

module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic [3:0]  m_valid;
    logic        m_frame;
    logic        m_err;
    logic [11:0] last;
    int          run;
    int          prev_cls;

    logic [6:0] code_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    // 0 = no anode, 1 = exactly one anode, 2 = several anodes
    function automatic int an_class(input logic [3:0] an);
        int z;
        z = 0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) z++;
        end
        return (z == 0) ? 0 : ((z == 1) ? 1 : 2);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [11:0] cur;
        logic [6:0]  pat;
        int          cls;
        int          d;
        int          v;
        if (!rst_n) begin
            m_bcd    = 16'hFFFF;
            m_dp     = '0;
            m_valid  = '0;
            m_frame  = 1'b0;
            m_err    = 1'b0;
            run      = 0;
            prev_cls = 0;
            return;
        end
        cur     = {an_n, seg_n};
        m_frame = 1'b0;
        m_err   = 1'b0;
        if (run > 0 && cur == last) begin
            if (run < 1000) run++;
        end else begin
            if (run > 0) prev_cls = an_class(last[11:8]);
            run  = 1;
            last = cur;
        end
        cls = an_class(cur[11:8]);
        if (run == SC + 1 && cls == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) begin
                if (!cur[8+i]) d = i;
            end
            pat = ~cur[6:0];
            v   = -1;
            for (int k = 0; k < 10; k++) begin
                if (code_tab[k] == pat) v = k;
            end
            m_dp[d] = ~cur[7];
            if (v >= 0) begin
                m_bcd[d*4 +: 4] = 4'(v);
                m_valid[d]      = 1'b1;
            end else begin
                m_bcd[d*4 +: 4] = 4'hF;
                m_valid[d]      = 1'b0;
                if (pat != 7'h00) m_err = 1'b1;
            end
            if (d == ND - 1) m_frame = 1'b1;
        end
        if (run == 2 && cls == 2 && prev_cls != 2) m_err = 1'b1;
    endtask

    task automatic check_output();
        check("bcd_out", bcd_out, m_bcd);
        check("dp_out", {12'h0, dp_out}, {12'h0, m_dp});
        check("valid", {12'h0, valid}, {12'h0, m_valid});
        check("frame_done", {15'h0, frame_done}, {15'h0, m_frame});
        check("err", {15'h0, err}, {15'h0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic rst, input logic [3:0] an,
                                  input logic [7:0] seg, input int cycles);
        rst_n = rst;
        an_n  = an;
        seg_n = seg;
        repeat (cycles) step();
    endtask

    initial begin
        logic [3:0] an;
        logic [7:0] seg;
        int         len;

        // Reset
        apply_stimulus(1'b0, 4'hF, 8'hFF, 3);
        check("reset_bcd", bcd_out, 16'hFFFF);
        check("reset_valid", {12'h0, valid}, 16'h0);

        // Single digit 2 on digit 0
        apply_stimulus(1'b1, 4'b1110, 8'hA4, 6);
        check("dig0_bcd", bcd_out, 16'hFFF2);
        check("dig0_valid", {12'h0, valid}, 16'h0001);

        // Full scan 1,2,3(dp),4
        apply_stimulus(1'b1, 4'b1110, 8'hF9, 5);
        apply_stimulus(1'b1, 4'b1101, 8'hA4, 5);
        apply_stimulus(1'b1, 4'b1011, 8'h30, 5);
        apply_stimulus(1'b1, 4'b0111, 8'h99, 5);
        check("scan_bcd", bcd_out, 16'h4321);
        check("scan_valid", {12'h0, valid}, 16'h000F);
        check("scan_dp", {12'h0, dp_out}, 16'h0004);
        apply_stimulus(1'b1, 4'hF, 8'hFF, 2);

        // Digit 1 toggling, then held at 3
        for (int t = 0; t < 3; t++) begin
            apply_stimulus(1'b1, 4'b1101, 8'hA4, 2);
            apply_stimulus(1'b1, 4'b1101, 8'hB0, 2);
        end
        apply_stimulus(1'b1, 4'b1101, 8'hB0, 4);
        check("toggle_bcd", bcd_out, 16'h4331);

        // Illegal pattern, then blank
        apply_stimulus(1'b1, 4'b1110, 8'hB6, 6);
        apply_stimulus(1'b1, 4'b1110, 8'hFF, 6);
        check("blank_bcd", bcd_out, 16'h433F);
        check("blank_valid", {12'h0, valid}, 16'h000E);

        // Illegal anodes, then digit 1 = 0
        apply_stimulus(1'b1, 4'b1100, 8'hC0, 10);
        apply_stimulus(1'b1, 4'b1101, 8'hC0, 6);
        check("anode_bcd", bcd_out, 16'h430F);

        // Reset in the middle of a dwell
        apply_stimulus(1'b1, 4'b1011, 8'h99, 3);
        apply_stimulus(1'b0, 4'b1011, 8'h99, 1);
        apply_stimulus(1'b1, 4'b1011, 8'h99, 4);
        check("rst_mid_pre", bcd_out, 16'hFFFF);
        apply_stimulus(1'b1, 4'b1011, 8'h99, 1);
        check("rst_mid_cap", bcd_out, 16'hF4FF);

        // Randomized dwells
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(0, 9))
                0: an = 4'hF;
                1: begin
                    an = 4'($urandom);
                    while (an_class(an) != 2) an = 4'($urandom);
                end
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 5))
                0: seg = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h7F;
                1: seg = 8'($urandom);
                default: seg = ~{1'($urandom), code_tab[$urandom_range(0, 9)]};
            endcase
            len = (an_class(an) == 2) ? int'($urandom_range(2, 7)) : int'($urandom_range(1, 8));
            if ($urandom_range(0, 40) == 0) begin
                apply_stimulus(1'b0, an, seg, 1);
            end
            apply_stimulus(1'b1, an, seg, len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
